mem_stage: RTL and testbench

//  Memory stage of the 5-stage pipeline, between the X/M latch (upstream) and the M/W latch (downstream).
//  ALU ops pass straight through. lw/sw run a req/ack transaction on the data-memory port; upstream stalls until it finishes.

---
 rtl/mem_stage.sv | 149 ++++++++++++++
 tb/tb_mem_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage: passes ALU ops through to M/W and runs lw/sw as a req/ack
// transaction on the data-memory port, stalling upstream until the access ends.
module mem_stage #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned TIMEOUT = 16,
    parameter logic [4:0]  LW_OP   = 5'b01000,
    parameter logic [4:0]  SW_OP   = 5'b00111
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       xm_ins,
    input  logic [31:0]       xm_o,
    input  logic [31:0]       xm_b,
    input  logic [31:0]       xm_ovf,
    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [31:0]       wb_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic [31:0]       mw_ins,
    output logic [31:0]       mw_o,
    output logic [31:0]       mw_d,
    output logic [31:0]       mw_ovf,
    output logic              mem_err
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  waitCnt;
    logic [31:0]       rdataQ;
    logic              errQ;

    logic [4:0]        opcode;
    logic              isLw;
    logic              isSw;
    logic              isMem;
    logic              fwdHit;
    logic [31:0]       fwdB;

    // Decode the X/M opcode and pick W-stage data for a store whose source is being written back.
    always_comb begin
        opcode = xm_ins[31:27];
        isLw   = (opcode == LW_OP);
        isSw   = (opcode == SW_OP);
        isMem  = isLw || isSw;
        fwdHit = wb_we && (wb_rd != 5'd0) && (wb_rd == xm_ins[26:22]);
        fwdB   = fwdHit ? wb_data : xm_b;
    end

    // Transaction FSM: issue on IDLE, wait for ack or timeout in BUSY, present result in HOLD.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            waitCnt   <= '0;
            rdataQ    <= '0;
            errQ      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (isMem) begin
                        state     <= BUSY;
                        mem_req   <= 1'b1;
                        mem_we    <= isSw;
                        mem_addr  <= xm_o[ADDR_W-1:0];
                        mem_wdata <= fwdB;
                        waitCnt   <= '0;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        rdataQ  <= mem_rdata;
                        errQ    <= 1'b0;
                        mem_req <= 1'b0;
                        state   <= HOLD;
                    end else if (waitCnt == CNT_LAST) begin
                        rdataQ  <= '0;
                        errQ    <= 1'b1;
                        mem_req <= 1'b0;
                        state   <= HOLD;
                    end else begin
                        waitCnt <= waitCnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    // Upstream advances on this same edge, so the op is never reissued.
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Stall and M/W payload: pass-through when idle, bubble while an access is pending.
    always_comb begin
        stall   = 1'b0;
        mw_ins  = '0;
        mw_o    = '0;
        mw_d    = '0;
        mw_ovf  = '0;
        mem_err = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (isMem) begin
                        stall = 1'b1;
                    end else begin
                        mw_ins = xm_ins;
                        mw_o   = xm_o;
                        mw_ovf = xm_ovf;
                    end
                end
                BUSY: begin
                    stall = 1'b1;
                end
                HOLD: begin
                    mw_ins  = xm_ins;
                    mw_o    = xm_o;
                    mw_ovf  = xm_ovf;
                    mw_d    = isLw ? rdataQ : 32'd0;
                    mem_err = errQ;
                end
                default: begin
                    stall = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios followed by random op sequences,
// checked against a transaction-level expectation of each instruction.
module tb_mem_stage;

    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned TIMEOUT = 16;
    localparam logic [4:0]  LW_OP   = 5'b01000;
    localparam logic [4:0]  SW_OP   = 5'b00111;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       xm_ins, xm_o, xm_b, xm_ovf;
    logic              wb_we;
    logic [4:0]        wb_rd;
    logic [31:0]       wb_data;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;
    logic              mem_ack;
    logic              stall;
    logic [31:0]       mw_ins, mw_o, mw_d, mw_ovf;
    logic              mem_err;

    int tests = 0;
    int fails = 0;

    mem_stage #(
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT),
        .LW_OP  (LW_OP),
        .SW_OP  (SW_OP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .xm_ins   (xm_ins),
        .xm_o     (xm_o),
        .xm_b     (xm_b),
        .xm_ovf   (xm_ovf),
        .wb_we    (wb_we),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .stall    (stall),
        .mw_ins   (mw_ins),
        .mw_o     (mw_o),
        .mw_d     (mw_d),
        .mw_ovf   (mw_ovf),
        .mem_err  (mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Non-memory op: must pass through in the same cycle with no bus activity.
    task automatic aluOp(input logic [31:0] ins, input logic [31:0] o, input logic [31:0] ovf,
                         input logic ack);
        @(posedge clk); #1;
        xm_ins = ins; xm_o = o; xm_b = $urandom; xm_ovf = ovf;
        wb_we = 1'b0; wb_rd = 5'd0; wb_data = $urandom;
        mem_ack = ack; mem_rdata = $urandom;
        @(negedge clk);
        check("alu_stall", 32'(stall), 32'd0);
        check("alu_ins",   mw_ins, ins);
        check("alu_o",     mw_o, o);
        check("alu_d",     mw_d, 32'd0);
        check("alu_ovf",   mw_ovf, ovf);
        check("alu_req",   32'(mem_req), 32'd0);
        check("alu_err",   32'(mem_err), 32'd0);
    endtask

    // lw/sw: ack arrives in BUSY cycle 'delay' (0-based); delay >= TIMEOUT means the bus never answers.
    task automatic memOp(input logic [4:0] op, input logic [4:0] rd, input logic [31:0] addrWord,
                         input logic [31:0] b, input logic wbWe, input logic [4:0] wbRd,
                         input logic [31:0] wbData, input int delay, input logic [31:0] rdata);
        logic [31:0] ins;
        logic [31:0] ovf;
        logic [31:0] expWdata;
        logic [31:0] expD;
        logic        expTimeout;
        int          expStalls;
        int          stalls;
        int          reqCycles;
        int          k;
        bit          done;

        ins        = {op, rd, 22'($urandom)};
        ovf        = $urandom;
        expWdata   = (wbWe && wbRd != 5'd0 && wbRd == rd) ? wbData : b;
        expTimeout = (delay >= int'(TIMEOUT));
        expStalls  = expTimeout ? int'(TIMEOUT) + 1 : delay + 2;
        expD       = (op == LW_OP && !expTimeout) ? rdata : 32'd0;

        @(posedge clk); #1;
        xm_ins = ins; xm_o = addrWord; xm_b = b; xm_ovf = ovf;
        wb_we = wbWe; wb_rd = wbRd; wb_data = wbData;
        mem_ack = 1'b0; mem_rdata = $urandom;
        @(negedge clk);
        check("issue_stall", 32'(stall), 32'd1);
        check("issue_ins",   mw_ins, 32'd0);
        check("issue_o",     mw_o, 32'd0);
        check("issue_req",   32'(mem_req), 32'd0);
        check("issue_err",   32'(mem_err), 32'd0);

        stalls = 1; reqCycles = 0; k = 0; done = 1'b0;
        while (!done) begin
            @(posedge clk); #1;
            mem_ack   = (k == delay);
            mem_rdata = (k == delay) ? rdata : $urandom;
            // Store data must have been captured at issue; disturb the bypass inputs.
            wb_we = 1'b1; wb_rd = rd; wb_data = $urandom;
            @(negedge clk);
            if (stall !== 1'b1) begin
                done = 1'b1;
            end else begin
                stalls++;
                reqCycles += int'(mem_req === 1'b1);
                check("busy_we",    32'(mem_we), 32'(op == SW_OP));
                check("busy_addr",  32'(mem_addr), addrWord & 32'hFFF);
                check("busy_wdata", mem_wdata, expWdata);
                check("busy_d",     mw_d, 32'd0);
                check("busy_err",   32'(mem_err), 32'd0);
            end
            k++;
            if (!done && k > int'(TIMEOUT) + 4) begin
                check("busy_bound", 32'(stall), 32'd0);
                done = 1'b1;
            end
        end

        check("stall_cycles", 32'(stalls), 32'(expStalls));
        check("req_cycles",   32'(reqCycles), 32'(expStalls - 1));
        check("hold_req",     32'(mem_req), 32'd0);
        check("hold_ins",     mw_ins, ins);
        check("hold_o",       mw_o, addrWord);
        check("hold_ovf",     mw_ovf, ovf);
        check("hold_d",       mw_d, expD);
        check("hold_err",     32'(mem_err), 32'(expTimeout));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0]  op;
        logic [4:0]  rd;
        logic        we;
        logic [4:0]  wr;
        int          dly;

        reset = 1'b1;
        xm_ins = {LW_OP, 27'd0}; xm_o = 32'h123; xm_b = 32'h55; xm_ovf = 32'h7;
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_mw_o",  mw_o, 32'd0);
        check("rst_mw_ins", mw_ins, 32'd0);
        check("rst_req",   32'(mem_req), 32'd0);
        check("rst_we",    32'(mem_we), 32'd0);
        check("rst_addr",  32'(mem_addr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_err",   32'(mem_err), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; xm_ins = 32'd0;

        // 1: add passes through
        aluOp({5'b00000, 27'h0123}, 32'd5, 32'd1, 1'b0);

        // 2: lw acked in the third BUSY cycle
        memOp(LW_OP, 5'd4, 32'h10, 32'h0, 1'b0, 5'd0, 32'h0, 2, 32'hCAFEF00D);

        // 3: sw forwarding hit, then register 0 never forwards
        memOp(SW_OP, 5'd5, 32'h20, 32'hFFFF, 1'b1, 5'd5, 32'h1234, 0, 32'hBAD);
        memOp(SW_OP, 5'd5, 32'h20, 32'hFFFF, 1'b1, 5'd0, 32'h1234, 0, 32'hBAD);
        memOp(SW_OP, 5'd0, 32'h24, 32'hFFFF, 1'b1, 5'd0, 32'h1234, 1, 32'hBAD);

        // 4: timeout with a late ack in HOLD, then ack in the last allowed cycle
        memOp(LW_OP, 5'd6, 32'h30, 32'h0, 1'b0, 5'd0, 32'h0, int'(TIMEOUT), 32'h11112222);
        aluOp({5'b00001, 27'h0}, 32'h99, 32'h0, 1'b0);
        memOp(LW_OP, 5'd6, 32'h34, 32'h0, 1'b0, 5'd0, 32'h0, int'(TIMEOUT) - 1, 32'h33334444);
        aluOp({5'b00001, 27'h0}, 32'h9A, 32'h0, 1'b0);

        // 5: reset in the second BUSY cycle, late ack ignored afterwards
        @(posedge clk); #1;
        xm_ins = {LW_OP, 5'd3, 22'd0}; xm_o = 32'h40; mem_ack = 1'b0; wb_we = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_mw_o",  mw_o, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; xm_ins = {5'b00010, 27'h5}; xm_o = 32'h77; xm_ovf = 32'h0;
        mem_ack = 1'b1; mem_rdata = 32'hDEAD;
        @(negedge clk);
        check("postrst_req",   32'(mem_req), 32'd0);
        check("postrst_stall", 32'(stall), 32'd0);
        check("postrst_o",     mw_o, 32'h77);
        check("postrst_d",     mw_d, 32'd0);
        check("postrst_err",   32'(mem_err), 32'd0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("postrst_req2",   32'(mem_req), 32'd0);
        check("postrst_stall2", 32'(stall), 32'd0);

        // 6: back-to-back lw, lw, add with immediate ack
        memOp(LW_OP, 5'd7, 32'h50, 32'h0, 1'b0, 5'd0, 32'h0, 0, 32'hAAAA0001);
        memOp(LW_OP, 5'd8, 32'h54, 32'h0, 1'b0, 5'd0, 32'h0, 0, 32'hAAAA0002);
        aluOp({5'b00011, 27'h42}, 32'h1000, 32'h2, 1'b0);

        // Random op stream
        for (int i = 0; i < 40; i++) begin
            case ($urandom % 3)
                0: begin
                    op = 5'($urandom);
                    if (op == LW_OP || op == SW_OP) op = 5'b00000;
                    aluOp({op, 27'($urandom)}, $urandom, $urandom, 1'($urandom));
                end
                default: begin
                    op  = ($urandom % 2 == 0) ? LW_OP : SW_OP;
                    rd  = 5'($urandom);
                    we  = 1'($urandom);
                    wr  = ($urandom % 2 == 0) ? rd : 5'($urandom);
                    dly = ($urandom % 4 == 0) ? int'($urandom_range(0, TIMEOUT + 1))
                                              : int'($urandom_range(0, 3));
                    memOp(op, rd, $urandom, $urandom, we, wr, $urandom, dly, $urandom);
                end
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
